// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and stalls FETCH, MEMREAD and MEMWRITE on the memory-ready handshake.
module mips_multicycle_control #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = STATE_W'(0),
    FETCH    = STATE_W'(1),
    DECODE   = STATE_W'(2),
    MEMADR   = STATE_W'(3),
    MEMREAD  = STATE_W'(4),
    MEMWB    = STATE_W'(5),
    MEMWRITE = STATE_W'(6),
    EXECUTE  = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    ADDIEX   = STATE_W'(10),
    ADDIWB   = STATE_W'(11),
    JUMP     = STATE_W'(12)
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   op_supported;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    op_supported = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                   (opcode == OP_BEQ) || (opcode == OP_J) ||
                   (ENABLE_ADDI && (opcode == OP_ADDI));
  end

  // The flag is set while leaving DECODE so it shows during the first FETCH cycle only.
  always_comb begin
    illegal_d = (state_q == DECODE) && !op_supported;
  end

  // NOTE: every output and state_d gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = MEMADR;
        else if (opcode == OP_RTYPE)                state_d = EXECUTE;
        else if (opcode == OP_BEQ)                  state_d = BRANCH;
        else if (opcode == OP_J)                    state_d = JUMP;
        else if (ENABLE_ADDI && (opcode == OP_ADDI)) state_d = ADDIEX;
        else                                        state_d = FETCH;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = MEMREAD;
        else if (opcode == OP_SW) state_d = MEMWRITE;
        else                      state_d = FETCH;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: directed instruction sequences push expected per-cycle state/outputs;
// a negedge monitor pops and compares both the default and the no-ADDI instance.
module tb_mips_multicycle_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, reset_na = 1'b1;
  logic [5:0] opcode = '0, opcode_na = '0;
  logic       mem_ready = 1'b0, mem_ready_na = 1'b0;

  logic a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_asa, a_ill;
  logic [1:0] a_asb, a_aop, a_pcs;
  logic [3:0] a_st;
  logic b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_asa, b_ill;
  logic [1:0] b_asb, b_aop, b_pcs;
  logic [3:0] b_st;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(a_pcw), .pc_write_cond(a_pcwc), .iord(a_iord), .mem_read(a_mr),
    .mem_write(a_mw), .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rd),
    .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
    .pc_source(a_pcs), .illegal_op(a_ill), .state(a_st)
  );

  mips_multicycle_control #(.ENABLE_ADDI(1'b0)) dut_na (
    .clk(clk), .reset(reset_na), .opcode(opcode_na), .mem_ready(mem_ready_na),
    .pc_write(b_pcw), .pc_write_cond(b_pcwc), .iord(b_iord), .mem_read(b_mr),
    .mem_write(b_mw), .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rd),
    .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
    .pc_source(b_pcs), .illegal_op(b_ill), .state(b_st)
  );

  // Observation word: {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
  typedef logic [20:0] obs_t;
  typedef struct packed { obs_t main; obs_t na; } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Expected outputs straight from the per-state output table.
  function automatic obs_t model(input logic [3:0] st, input logic mr, input logic ill);
    logic pcw, pcwc, io, mrd, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, io, mrd, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1'b1; asb = 2'b10; end
      4'd4:  begin mrd = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; end
      4'd7:  begin asa = 1'b1; aop = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: rw = 1'b1;
      4'd12: begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {st, pcw, pcwc, io, mrd, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got state=%0d outs=%05h, expected state=%0d outs=%05h",
               name, cyc, act[20:17], act[16:0], exp[20:17], exp[16:0]);
    end
  endtask

  // Monitor: every cycle is an output presentation; sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("main", {a_st, a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw,
                     a_asa, a_asb, a_aop, a_pcs, a_ill}, e.main);
      check("no_addi", {b_st, b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw,
                        b_asa, b_asb, b_aop, b_pcs, b_ill}, e.na);
      cyc++;
    end
  end

  // Drive the default instance for one cycle; the no-ADDI instance is held in reset.
  task automatic step_main(input logic rst, input logic [5:0] op, input logic mr,
                           input logic [3:0] st, input logic ill);
    reset = rst; opcode = op; mem_ready = mr;
    reset_na = 1'b1; opcode_na = '0; mem_ready_na = 1'b0;
    exp_q.push_back('{main: model(st, mr, ill), na: model(4'd0, 1'b0, 1'b0)});
    @(posedge clk); #1;
  endtask

  // Drive the no-ADDI instance for one cycle; the default instance is held in reset.
  task automatic step_na(input logic rst, input logic [5:0] op, input logic mr,
                         input logic [3:0] st, input logic ill);
    reset = 1'b1; opcode = '0; mem_ready = 1'b0;
    reset_na = rst; opcode_na = op; mem_ready_na = mr;
    exp_q.push_back('{main: model(4'd0, 1'b0, 1'b0), na: model(st, mr, ill)});
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // lw, no stalls: 0,1,2,3,4,5,1
    step_main(0, LW, 1, 0, 0);
    step_main(0, LW, 1, 1, 0);
    step_main(0, LW, 1, 2, 0);
    step_main(0, LW, 1, 3, 0);
    step_main(0, LW, 1, 4, 0);
    step_main(0, LW, 1, 5, 0);
    // R-type
    step_main(0, RT, 1, 1, 0);
    step_main(0, RT, 1, 2, 0);
    step_main(0, RT, 1, 7, 0);
    step_main(0, RT, 1, 8, 0);
    // beq
    step_main(0, BEQ, 1, 1, 0);
    step_main(0, BEQ, 1, 2, 0);
    step_main(0, BEQ, 1, 9, 0);
    // sw with three stall cycles in MEMWRITE
    step_main(0, SW, 1, 1, 0);
    step_main(0, SW, 1, 2, 0);
    step_main(0, SW, 0, 3, 0);
    step_main(0, SW, 0, 6, 0);
    step_main(0, SW, 0, 6, 0);
    step_main(0, SW, 0, 6, 0);
    step_main(0, SW, 1, 6, 0);
    // stalled fetch of an illegal opcode
    step_main(0, BAD, 0, 1, 0);
    step_main(0, BAD, 0, 1, 0);
    step_main(0, BAD, 1, 1, 0);
    step_main(0, BAD, 1, 2, 0);
    // illegal pulse in first FETCH, then addi enabled
    step_main(0, ADDI, 1, 1, 1);
    step_main(0, ADDI, 1, 2, 0);
    step_main(0, ADDI, 1, 10, 0);
    step_main(0, ADDI, 1, 11, 0);
    // jump
    step_main(0, J, 1, 1, 0);
    step_main(0, J, 1, 2, 0);
    step_main(0, J, 1, 12, 0);
    // lw stalled in MEMREAD, then reset mid-stall
    step_main(0, LW, 1, 1, 0);
    step_main(0, LW, 1, 2, 0);
    step_main(0, LW, 0, 3, 0);
    step_main(0, LW, 0, 4, 0);
    step_main(1, LW, 0, 4, 0);
    step_main(1, LW, 1, 0, 0);
    // no-ADDI instance: addi is illegal; pulse lasts one cycle even while FETCH stalls
    step_na(0, ADDI, 1, 0, 0);
    step_na(0, ADDI, 1, 1, 0);
    step_na(0, ADDI, 1, 2, 0);
    step_na(0, LW, 0, 1, 1);
    step_na(0, LW, 1, 1, 0);
    step_na(0, LW, 1, 2, 0);
    step_na(0, LW, 1, 3, 0);
    step_na(0, LW, 1, 4, 0);
    step_na(0, LW, 1, 5, 0);
    step_na(0, LW, 1, 1, 0);
    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
